// File: rtl/console_rx_pkg.sv
// Shared constants for the console receive peripheral: window base, register
// offsets, CTRL bit positions and small decode/packing helpers.
package console_rx_pkg;

    localparam logic [31:0] CONSOLE_RX_BASE = 32'h8000_5000;

    localparam logic [3:0] CRX_DATA   = 4'h0;
    localparam logic [3:0] CRX_STATUS = 4'h4;
    localparam logic [3:0] CRX_CTRL   = 4'h8;
    localparam logic [3:0] CRX_THRESH = 4'hC;

    localparam int CTRL_IRQ_EN  = 0;
    localparam int CTRL_CLR_OVF = 1;
    localparam int CTRL_FLUSH   = 2;

    typedef enum logic [1:0] {
        REG_DATA,
        REG_STATUS,
        REG_CTRL,
        REG_THRESH
    } crx_reg_e;

    // Byte-offset bits are ignored; every word in the 16-byte window is mapped.
    function automatic crx_reg_e crx_decode(input logic [3:0] offset);
        crx_reg_e sel;
        case ({offset[3:2], 2'b00})
            CRX_DATA:   sel = REG_DATA;
            CRX_STATUS: sel = REG_STATUS;
            CRX_CTRL:   sel = REG_CTRL;
            CRX_THRESH: sel = REG_THRESH;
            default:    sel = REG_DATA;
        endcase
        return sel;
    endfunction

    function automatic logic [31:0] crx_status_word(input logic       not_empty,
                                                    input logic       full,
                                                    input logic       overflow,
                                                    input logic [8:0] count);
        return {15'b0, count, 5'b0, overflow, full, not_empty};
    endfunction

endpackage

// File: rtl/console_rx_if.sv
// CPU bus window plus host byte stream of the console receiver, bundled so the
// peripheral and its drivers see one connection.
interface console_rx_if;

    logic        en_i;
    logic [3:0]  we_i;
    logic [3:0]  addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        rx_valid_i;
    logic [7:0]  rx_data_i;
    logic        rx_ready_o;
    logic        irq_o;

    modport master (
        output en_i, we_i, addr_i, data_i, rx_valid_i, rx_data_i,
        input  data_o, rx_ready_o, irq_o
    );

    modport slave (
        input  en_i, we_i, addr_i, data_i, rx_valid_i, rx_data_i,
        output data_o, rx_ready_o, irq_o
    );

endinterface

// File: rtl/console_rx_fifo.sv
// Byte FIFO for the console receiver: power-of-two depth, naturally wrapping
// pointers, full evaluated before any same-cycle pop.
module console_rx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flush discards everything, including a byte offered in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW + 1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW + 1)'(1);
            end
        end
    end

endmodule

// File: rtl/console_rx.sv
// Console receive peripheral: host bytes queue in a FIFO, the CPU drains them
// through a four-register window, and a level IRQ fires at a fill threshold.
module console_rx
    import console_rx_pkg::*;
#(
    parameter int          DEPTH     = 16,
    parameter logic [31:0] BASE_ADDR = CONSOLE_RX_BASE
) (
    input logic         clk,
    input logic         reset,
    console_rx_if.slave bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    crx_reg_e      reg_sel;
    logic          bus_read;
    logic          bus_write;
    logic          ctrl_write;
    logic          pop;
    logic          push;
    logic          flush;
    logic [7:0]    head;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic          full;
    logic          empty;
    logic          irq_en;
    logic          overflow;
    logic [8:0]    thresh;
    logic [8:0]    thresh_eff;
    logic [31:0]   rd_word;
    logic [31:0]   data_q;
    logic          irq_q;
    logic          unused_ok;

    assign reg_sel    = crx_decode(bus.addr_i);
    assign bus_read   = bus.en_i && (bus.we_i == 4'b0000);
    assign bus_write  = bus.en_i && (bus.we_i != 4'b0000);
    assign ctrl_write = bus_write && (reg_sel == REG_CTRL) && bus.we_i[0];
    assign pop        = bus_read && (reg_sel == REG_DATA);
    assign flush      = ctrl_write && bus.data_i[CTRL_FLUSH];
    assign push       = bus.rx_valid_i && !full;
    assign thresh_eff = (thresh == 9'd0) ? 9'd1 : thresh;

    assign bus.rx_ready_o = !full;
    assign bus.data_o     = data_q;
    assign bus.irq_o      = irq_q;

    // The window base is decoded upstream; high lanes and byte offsets carry nothing here.
    assign unused_ok = ^{bus.data_i[31:16], bus.we_i[3:2], bus.addr_i[1:0], BASE_ADDR};

    console_rx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.rx_valid_i),
        .pop   (pop),
        .flush (flush),
        .wdata (bus.rx_data_i),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // Mirror of the FIFO's next occupancy so the interrupt tracks the same edge.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push && !(pop && !empty)) begin
            count_next = count + CW'(1);
        end else if (!push && pop && !empty) begin
            count_next = count - CW'(1);
        end
    end

    always_comb begin
        rd_word = '0;
        case (reg_sel)
            REG_DATA: begin
                if (!empty) begin
                    rd_word = {23'b0, 1'b1, head};
                end
            end
            REG_STATUS: rd_word = crx_status_word(!empty, full, overflow, 9'(count));
            REG_CTRL:   rd_word[CTRL_IRQ_EN] = irq_en;
            REG_THRESH: rd_word[8:0] = thresh;
            default:    rd_word = '0;
        endcase
    end

    // Clear-overflow and flush are pulses, so only irq_en is stored from CTRL.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q   <= '0;
            irq_q    <= 1'b0;
            irq_en   <= 1'b0;
            overflow <= 1'b0;
            thresh   <= 9'd1;
        end else begin
            if (bus_read) begin
                data_q <= rd_word;
            end
            irq_q <= irq_en && ((CW + 9)'(count_next) >= (CW + 9)'(thresh_eff));
            if (ctrl_write) begin
                irq_en <= bus.data_i[CTRL_IRQ_EN];
            end
            if (bus_write && (reg_sel == REG_THRESH)) begin
                if (bus.we_i[0]) begin
                    thresh[7:0] <= bus.data_i[7:0];
                end
                if (bus.we_i[1]) begin
                    thresh[8] <= bus.data_i[8];
                end
            end
            if (bus.rx_valid_i && full) begin
                overflow <= 1'b1;
            end else if (ctrl_write && bus.data_i[CTRL_CLR_OVF]) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: doc/console_rx.md
Name: console_rx

Overview:
- Memory-mapped character-input peripheral: the receive side of the simulation console, complementing the byte-output register at 0x8000_4000.
- Host/testbench side pushes bytes through a valid/ready stream into an internal FIFO.
- CPU side reads those bytes through the data-bus decode window (base 0x8000_5000).
- Raises a level interrupt on PLIC source 1 once the fill level reaches a programmable threshold.

Parameters:
DEPTH, 16, FIFO entries; power of two, 2..256
BASE_ADDR, 32'h8000_5000, bus window base; addr_i[3:0] selects the register

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high reset
en_i  in  1  bus select (decoded mem_operation_enable for this window)
we_i  in  4  byte write enables; '0 = read
addr_i  in  4  register offset (word aligned; bits[1:0] ignored)
data_i  in  32  write data
data_o  out  32  read data, valid the cycle after en_i
rx_valid_i  in  1  host byte valid
rx_data_i  in  8  host byte
rx_ready_o  out  1  host may push (= !full)
irq_o  out  1  level interrupt to PLIC irq_i[1]

Behaviour:
- Reset values: data_o = 0, irq_o = 0, FIFO empty, rx_ready_o = 1, ctrl = 0, threshold = 1, overflow = 0.
- Push:
  - Occurs on a clock edge when rx_valid_i && rx_ready_o.
  - rx_ready_o is combinational !full.
  - Full is evaluated before any same-cycle pop, so a push while full is never accepted, even with a simultaneous pop.
  - rx_valid_i && !rx_ready_o sets sticky overflow bit; the byte is dropped.
- Registers, read latency 1 (data_o registered, updated only when en_i && we_i == 0; otherwise holds its value):
  - 0x0 DATA, read: pops if not empty.
    - Non-empty: data_o = {23'b0, 1'b1, head_byte}.
    - Empty: data_o = 0, no pointer change.
  - 0x0 DATA, write: ignored.
  - 0x4 STATUS, read-only: bit0 = !empty, bit1 = full, bit2 = overflow, bits[16:8] = count (9-bit), rest 0.
  - 0x8 CTRL, read/write:
    - bit0 irq_en.
    - bit1 write-1 clears overflow (self-clearing, reads 0).
    - bit2 write-1 flushes the FIFO (self-clearing, reads 0).
  - 0xC THRESH, read/write: bits[8:0], 0 treated as 1.
  - Writes use we_i[0] for bits[7:0] and we_i[1] for bits[15:8]; higher lanes are ignored.
- Pointers: rd_ptr/wr_ptr are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits, never exceeds DEPTH and never underflows.
- Simultaneous push and pop (not full, not empty): count unchanged; both pointers advance.
- Push into empty FIFO with simultaneous DATA read: no bypass. The read returns empty (0) and the byte remains for the next read.
- Flush with simultaneous push: flush wins and the pushed byte is discarded. Overflow is not affected by flush.
- irq_o registered: irq_o <= irq_en && (count_next >= max(THRESH, 1)). It deasserts the cycle after the pop that drops count below THRESH.
- Reset asserted mid-stream: all state returns to reset values on that edge; a push in the reset cycle is discarded and rx_ready_o is 1 the following cycle.
- Unmapped offsets: read returns 0, writes are ignored.

Decomposition:
- RS5_pkg additions:
  - CONSOLE_RX_BASE.
  - Offset constants CRX_DATA = 4'h0, CRX_STATUS = 4'h4, CRX_CTRL = 4'h8, CRX_THRESH = 4'hC.
  - CTRL bit-index constants.
- Sub-module console_rx_fifo: parameter DEPTH; ports push, pop, flush, wdata, rdata, count, full, empty. Storage is an unpacked array with no reset on the data.
- The top handles the register decode, the data_o register, overflow, and irq.

Test Plan:
1. Reset, then push 0x41, 0x42, 0x43; read STATUS -> data_o = 0x0000_0301. DATA reads return 0x141, 0x142, 0x143, then 0x000.
2. Push DEPTH = 16 bytes -> rx_ready_o = 0, STATUS = 0x0000_1003. A 17th rx_valid_i sets overflow -> STATUS = 0x0000_1007. CTRL write 0x2 -> STATUS = 0x0000_1003.
3. THRESH = 3, CTRL = 0x1; push 2 bytes -> irq_o = 0. Push a 3rd -> irq_o = 1 on the next cycle. One DATA read -> irq_o = 0 the cycle after the pop.
4. FIFO full; DATA read and push in the same cycle -> push rejected (ready low), count becomes 15. Next cycle a push is accepted -> count 16, byte order preserved across pointer wrap.
5. Empty FIFO; push 0x55 in the same cycle as a DATA read -> data_o = 0. Next read -> 0x155.
6. 5 bytes queued; CTRL write 0x4 with a concurrent push -> STATUS = 0. Assert reset mid-stream with 3 bytes queued -> STATUS = 0, irq_o = 0, THRESH reads 1.
